aes_decrypt_round_seq: RTL and testbench

//  Iterative sequencer for the modified AES-256 decrypt path. It sits directly upstream
//   of the combinational decrypt-round stage.
//  - Accepts a ciphertext block and an S-box seed.
//  - Performs the initial whitening with round key 14.
//  - Then drives the round stage once per cycle for round_num 14..1, fetching keys 13..0.
//  - Registers each round result and presents the plaintext with a valid/ready handshake.

---
 rtl/aes_dec_pkg.sv | 16 +
 rtl/aes_decrypt_round_seq.sv | 129 ++++++++++++
 tb/tb_aes_decrypt_round_seq.sv | 220 ++++++++++++++++++++++
 3 files changed

// File: rtl/aes_dec_pkg.sv
// Shared types and constants for the AES-256 decrypt round sequencer.
package aes_dec_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    WHITEN = 2'd1,
    ROUND  = 2'd2,
    DONE   = 2'd3
  } dec_state_e;

  localparam int NR     = 14;
  localparam int BLK_W  = 128;
  localparam int SEED_W = 256;
  localparam int RNUM_W = 32;

endpackage

// File: rtl/aes_decrypt_round_seq.sv
// Iterative sequencer driving the external decrypt-round stage: whitening, NR rounds, handshake out.
// Optional completed-block counter enabled with `define DEC_BLOCK_CNT_EN.
module aes_decrypt_round_seq
  import aes_dec_pkg::*;
#(
  parameter int NR         = aes_dec_pkg::NR,
  parameter int KEY_ADDR_W = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [BLK_W-1:0]      in_data,
  input  logic [SEED_W-1:0]     in_seed,
  output logic [KEY_ADDR_W-1:0] rk_addr,
  input  logic [BLK_W-1:0]      rk_data,
  output logic [BLK_W-1:0]      rnd_in,
  output logic [BLK_W-1:0]      rnd_key,
  output logic [SEED_W-1:0]     rnd_seed,
  output logic [RNUM_W-1:0]     rnd_num,
  input  logic [BLK_W-1:0]      rnd_out,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [BLK_W-1:0]      out_data
`ifdef DEC_BLOCK_CNT_EN
  ,
  output logic [RNUM_W-1:0]     blk_cnt
`endif
);

  dec_state_e            r_state;
  logic [BLK_W-1:0]      r_blk;
  logic [SEED_W-1:0]     r_seed;
  logic [RNUM_W-1:0]     r_rnd_num;
  logic [KEY_ADDR_W-1:0] r_rk_addr;

  dec_state_e            w_state_nxt;
  logic [BLK_W-1:0]      w_blk_nxt;
  logic [SEED_W-1:0]     w_seed_nxt;
  logic [RNUM_W-1:0]     w_rnd_num_nxt;
  logic [KEY_ADDR_W-1:0] w_rk_addr_nxt;
  logic                  w_out_hs;

  // The key store answers rk_addr in the cycle it is presented, so rk_addr always leads by one round.
  always_comb begin
    w_state_nxt   = r_state;
    w_blk_nxt     = r_blk;
    w_seed_nxt    = r_seed;
    w_rnd_num_nxt = r_rnd_num;
    w_rk_addr_nxt = r_rk_addr;
    w_out_hs      = 1'b0;
    case (r_state)
      IDLE: begin
        if (in_valid) begin
          w_blk_nxt     = in_data;
          w_seed_nxt    = in_seed;
          w_rk_addr_nxt = KEY_ADDR_W'(NR);
          w_state_nxt   = WHITEN;
        end
      end
      WHITEN: begin
        w_blk_nxt     = r_blk ^ rk_data;
        w_rnd_num_nxt = RNUM_W'(NR);
        w_rk_addr_nxt = KEY_ADDR_W'(NR - 1);
        w_state_nxt   = ROUND;
      end
      ROUND: begin
        w_blk_nxt = rnd_out;
        if (r_rnd_num > RNUM_W'(1)) begin
          w_rnd_num_nxt = r_rnd_num - RNUM_W'(1);
          w_rk_addr_nxt = KEY_ADDR_W'(r_rnd_num - RNUM_W'(2));
        end else begin
          w_state_nxt = DONE;
        end
      end
      DONE: begin
        if (out_ready) begin
          w_out_hs    = 1'b1;
          w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state   <= IDLE;
      r_blk     <= '0;
      r_seed    <= '0;
      r_rnd_num <= '0;
      r_rk_addr <= KEY_ADDR_W'(NR);
    end else begin
      r_state   <= w_state_nxt;
      r_blk     <= w_blk_nxt;
      r_seed    <= w_seed_nxt;
      r_rnd_num <= w_rnd_num_nxt;
      r_rk_addr <= w_rk_addr_nxt;
    end
  end

`ifdef DEC_BLOCK_CNT_EN
  logic [RNUM_W-1:0] r_blk_cnt;

  // Assigned only on reset or handshake so a preloaded value survives idle cycles.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_blk_cnt <= '0;
    end else if (w_out_hs) begin
      r_blk_cnt <= r_blk_cnt + RNUM_W'(1);
    end
  end

  assign blk_cnt = r_blk_cnt;
`else
  logic w_unused_hs;
  assign w_unused_hs = w_out_hs;
`endif

  assign in_ready  = (r_state == IDLE);
  assign out_valid = (r_state == DONE);
  assign out_data  = r_blk;
  assign rnd_in    = r_blk;
  assign rnd_key   = rk_data;
  assign rnd_seed  = r_seed;
  assign rnd_num   = r_rnd_num;
  assign rk_addr   = r_rk_addr;

endmodule

// File: tb/tb_aes_decrypt_round_seq.sv
// Directed bench for aes_decrypt_round_seq with a stub round stage (state ^ key ^ round number).
// Build with `define DEC_BLOCK_CNT_EN to also exercise the block counter.
module tb_aes_decrypt_round_seq;

  localparam logic [127:0] CT1   = 128'h8ea2b7ca516745bfeafc49904b496089;
  localparam logic [127:0] PT1   = 128'h8ea2b7ca516745bfeafc49904b491f79;
  localparam logic [127:0] CT2   = 128'h0;
  localparam logic [127:0] PT2   = 128'h7ff0;
  localparam logic [127:0] CT3   = {128{1'b1}};
  localparam logic [127:0] PT3   = 128'hffffffffffffffffffffffffffff800f;
  localparam logic [255:0] SEED1 = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
  localparam logic [255:0] SEED2 = {8{32'hdeadbeef}};

  logic         clk;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] in_data;
  logic [255:0] in_seed;
  logic [3:0]   rk_addr;
  logic [127:0] rk_data;
  logic [127:0] rnd_in;
  logic [127:0] rnd_key;
  logic [255:0] rnd_seed;
  logic [31:0]  rnd_num;
  logic [127:0] rnd_out;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] out_data;
`ifdef DEC_BLOCK_CNT_EN
  logic [31:0]  blk_cnt;
`endif

  logic [127:0] keys [0:15];
  int nChecks = 0;
  int nFail   = 0;

  aes_decrypt_round_seq dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .in_seed  (in_seed),
    .rk_addr  (rk_addr),
    .rk_data  (rk_data),
    .rnd_in   (rnd_in),
    .rnd_key  (rnd_key),
    .rnd_seed (rnd_seed),
    .rnd_num  (rnd_num),
    .rnd_out  (rnd_out),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data)
`ifdef DEC_BLOCK_CNT_EN
    ,
    .blk_cnt  (blk_cnt)
`endif
  );

  // Key i has only bit i set, so all 15 keys XOR to 0x7fff and round numbers 14..1 XOR to 0xf.
  assign rk_data = keys[rk_addr];
  assign rnd_out = rnd_in ^ rnd_key ^ {96'b0, rnd_num};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic sendBlock(input logic [127:0] ct, input logic [255:0] seed);
    in_valid = 1'b1;
    in_data  = ct;
    in_seed  = seed;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic drainBlock();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_data = '0; in_seed = '0;
    tick(); tick();
    nChecks++; if (in_ready !== 1'b1) begin nFail++; $display("[TB] FAIL reset_in_ready: got %b expected 1", in_ready); end
    nChecks++; if (out_valid !== 1'b0) begin nFail++; $display("[TB] FAIL reset_out_valid: got %b expected 0", out_valid); end
    nChecks++; if (rk_addr !== 4'd14) begin nFail++; $display("[TB] FAIL reset_rk_addr: got %0d expected 14", rk_addr); end
    nChecks++; if (rnd_num !== 32'd0) begin nFail++; $display("[TB] FAIL reset_rnd_num: got %0d expected 0", rnd_num); end
    nChecks++; if (out_data !== 128'h0) begin nFail++; $display("[TB] FAIL reset_out_data: got %h expected 0", out_data); end
    nChecks++; if (rnd_seed !== 256'h0) begin nFail++; $display("[TB] FAIL reset_seed: got %h expected 0", rnd_seed); end
`ifdef DEC_BLOCK_CNT_EN
    nChecks++; if (blk_cnt !== 32'd0) begin nFail++; $display("[TB] FAIL reset_blk_cnt: got %0d expected 0", blk_cnt); end
`endif
    rst_n = 1'b1;
  endtask

  task automatic test_fips_vector();
    sendBlock(CT1, SEED1);
    repeat (14) tick();
    nChecks++; if (out_valid !== 1'b0) begin nFail++; $display("[TB] FAIL fips_early_valid: got %b expected 0 at cycle 15", out_valid); end
    tick();
    nChecks++; if (out_valid !== 1'b1) begin nFail++; $display("[TB] FAIL fips_valid: got %b expected 1 at cycle 16", out_valid); end
    nChecks++; if (out_data !== PT1) begin nFail++; $display("[TB] FAIL fips_data: got %h expected %h", out_data, PT1); end
    nChecks++; if (in_ready !== 1'b0) begin nFail++; $display("[TB] FAIL fips_in_ready_busy: got %b expected 0", in_ready); end
    drainBlock();
    nChecks++; if (out_valid !== 1'b0) begin nFail++; $display("[TB] FAIL fips_valid_drop: got %b expected 0", out_valid); end
    nChecks++; if (in_ready !== 1'b1) begin nFail++; $display("[TB] FAIL fips_in_ready_idle: got %b expected 1", in_ready); end
  endtask

  task automatic test_key_trace();
    sendBlock(CT2, SEED2);
    for (int k = 1; k <= 15; k++) begin
      nChecks++; if (rk_addr !== 4'(15 - k)) begin nFail++; $display("[TB] FAIL trace_rk_addr c%0d: got %0d expected %0d", k, rk_addr, 15 - k); end
      if (k >= 2) begin
        nChecks++; if (rnd_num !== 32'(16 - k)) begin nFail++; $display("[TB] FAIL trace_rnd_num c%0d: got %0d expected %0d", k, rnd_num, 16 - k); end
        nChecks++; if (rnd_key !== (128'd1 << (15 - k))) begin nFail++; $display("[TB] FAIL trace_rnd_key c%0d: got %h expected bit %0d", k, rnd_key, 15 - k); end
        nChecks++; if (rnd_seed !== SEED2) begin nFail++; $display("[TB] FAIL trace_seed c%0d: got %h expected %h", k, rnd_seed, SEED2); end
      end
      tick();
    end
    nChecks++; if (rk_addr !== 4'd0) begin nFail++; $display("[TB] FAIL trace_rk_addr_final: got %0d expected 0", rk_addr); end
    nChecks++; if (out_data !== PT2) begin nFail++; $display("[TB] FAIL trace_data: got %h expected %h", out_data, PT2); end
    drainBlock();
  endtask

  task automatic test_backpressure();
    sendBlock(CT1, SEED1);
    repeat (15) tick();
    in_valid = 1'b1; in_data = CT3; in_seed = SEED2;
    for (int i = 0; i < 10; i++) begin
      nChecks++; if (out_valid !== 1'b1) begin nFail++; $display("[TB] FAIL bp_valid c%0d: got %b expected 1", i, out_valid); end
      nChecks++; if (out_data !== PT1) begin nFail++; $display("[TB] FAIL bp_data c%0d: got %h expected %h", i, out_data, PT1); end
      nChecks++; if (in_ready !== 1'b0) begin nFail++; $display("[TB] FAIL bp_in_ready c%0d: got %b expected 0", i, in_ready); end
`ifdef DEC_BLOCK_CNT_EN
      nChecks++; if (blk_cnt !== 32'd2) begin nFail++; $display("[TB] FAIL bp_blk_cnt c%0d: got %0d expected 2", i, blk_cnt); end
`endif
      tick();
    end
    in_valid = 1'b0;
    drainBlock();
    nChecks++; if (out_valid !== 1'b0) begin nFail++; $display("[TB] FAIL bp_release: got %b expected 0", out_valid); end
  endtask

  task automatic test_ignore_busy();
    sendBlock(CT1, SEED1);
    repeat (4) tick();
    in_valid = 1'b1; in_data = CT2; in_seed = SEED2;
    tick(); tick();
    in_valid = 1'b0;
    nChecks++; if (rnd_seed !== SEED1) begin nFail++; $display("[TB] FAIL ignore_seed: got %h expected %h", rnd_seed, SEED1); end
    repeat (9) tick();
    nChecks++; if (out_valid !== 1'b1) begin nFail++; $display("[TB] FAIL ignore_valid: got %b expected 1", out_valid); end
    nChecks++; if (out_data !== PT1) begin nFail++; $display("[TB] FAIL ignore_data: got %h expected %h", out_data, PT1); end
    drainBlock();
  endtask

  task automatic test_mid_reset();
    sendBlock(CT1, SEED1);
    repeat (7) tick();
    rst_n = 1'b0;
    tick();
    nChecks++; if (out_valid !== 1'b0) begin nFail++; $display("[TB] FAIL midrst_valid: got %b expected 0", out_valid); end
    nChecks++; if (in_ready !== 1'b1) begin nFail++; $display("[TB] FAIL midrst_in_ready: got %b expected 1", in_ready); end
    nChecks++; if (rnd_num !== 32'd0) begin nFail++; $display("[TB] FAIL midrst_rnd_num: got %0d expected 0", rnd_num); end
    rst_n = 1'b1;
    sendBlock(CT3, SEED2);
    repeat (15) tick();
    nChecks++; if (out_valid !== 1'b1) begin nFail++; $display("[TB] FAIL midrst_new_valid: got %b expected 1", out_valid); end
    nChecks++; if (out_data !== PT3) begin nFail++; $display("[TB] FAIL midrst_new_data: got %h expected %h", out_data, PT3); end
    drainBlock();
  endtask

`ifdef DEC_BLOCK_CNT_EN
  task automatic test_blk_cnt();
    logic [31:0] expCnt [0:2];
    expCnt[0] = 32'd1; expCnt[1] = 32'd2; expCnt[2] = 32'd0;
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    for (int b = 0; b < 3; b++) begin
      if (b == 2) begin
        force dut.r_blk_cnt = 32'hffffffff;
        tick();
        release dut.r_blk_cnt;
      end
      sendBlock(CT2, SEED1);
      repeat (15) tick();
      drainBlock();
      nChecks++; if (blk_cnt !== expCnt[b]) begin nFail++; $display("[TB] FAIL blk_cnt b%0d: got %h expected %h", b, blk_cnt, expCnt[b]); end
    end
  endtask
`endif

  initial begin
    for (int i = 0; i < 16; i++) keys[i] = 128'd1 << i;
    test_reset();
    test_fips_vector();
    test_key_trace();
    test_backpressure();
    test_ignore_busy();
    test_mid_reset();
`ifdef DEC_BLOCK_CNT_EN
    test_blk_cnt();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
    $finish;
  end

endmodule
